// File: rtl/trap_pkg.sv
// trap_pkg: shared constants and types for the trap sequencer.
//   - CSR addresses written by the sequencer
//   - Ecode used for interrupts
//   - ESTAT field offsets and EENTRY alignment
//   - FSM state and event-kind enumerations
package trap_pkg;

    localparam logic [13:0] CSR_CRMD  = 14'h0;
    localparam logic [13:0] CSR_PRMD  = 14'h1;
    localparam logic [13:0] CSR_ESTAT = 14'h5;
    localparam logic [13:0] CSR_ERA   = 14'h6;
    localparam logic [13:0] CSR_BADV  = 14'h7;

    localparam logic [5:0] ECODE_INT = 6'h0;

    localparam int ESTAT_ECODE_LSB = 16;
    localparam int ESTAT_ESUB_LSB  = 22;
    localparam int EENTRY_ALIGN    = 6;

    typedef enum logic [2:0] {
        IDLE,
        W_ESTAT,
        W_ERA,
        W_BADV,
        W_PRMD,
        W_CRMD,
        E_CRMD,
        REDIRECT
    } state_e;

    // What started the current sequence; ERTN shares the REDIRECT state
    // with traps, so the kind selects the redirect target.
    typedef enum logic [1:0] {
        EV_EXC,
        EV_INT,
        EV_ERTN
    } ev_kind_e;

endpackage

// File: rtl/trap_arbiter.sv
// trap_arbiter: combinational priority select over the stage exception
// sources and the maskable interrupt.
//   src_*        packed per-source exception fields (source i in slice i)
//   int_pending  level interrupt lines, gated by ecfg_lie and crmd_ie
//   int_pc       PC recorded for an interrupt
//   valid/kind/ecode/esubcode/pc/badv/badv_vld  winning event
module trap_arbiter
    import trap_pkg::*;
#(
    parameter int NSRC = 5,
    parameter int NINT = 13,
    parameter int XLEN = 32
) (
    input  logic [NSRC-1:0]      src_ex,
    input  logic [NSRC*6-1:0]    src_ecode,
    input  logic [NSRC*9-1:0]    src_esubcode,
    input  logic [NSRC-1:0]      src_badv_vld,
    input  logic [NSRC*XLEN-1:0] src_badv,
    input  logic [NSRC*XLEN-1:0] src_pc,
    input  logic [NINT-1:0]      int_pending,
    input  logic [NINT-1:0]      ecfg_lie,
    input  logic                 crmd_ie,
    input  logic [XLEN-1:0]      int_pc,
    output logic                 valid,
    output ev_kind_e             kind,
    output logic [5:0]           ecode,
    output logic [8:0]           esubcode,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      badv,
    output logic                 badv_vld
);

    logic int_req;
    assign int_req = crmd_ie & |(int_pending & ecfg_lie);

    // Interrupt is the lowest priority; sources are scanned upward so the
    // highest asserted index (oldest stage) overwrites everything below.
    always_comb begin
        valid    = 1'b0;
        kind     = EV_EXC;
        ecode    = '0;
        esubcode = '0;
        pc       = '0;
        badv     = '0;
        badv_vld = 1'b0;
        if (int_req) begin
            valid = 1'b1;
            kind  = EV_INT;
            ecode = ECODE_INT;
            pc    = int_pc;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (src_ex[i]) begin
                valid    = 1'b1;
                kind     = EV_EXC;
                ecode    = src_ecode[6*i +: 6];
                esubcode = src_esubcode[9*i +: 9];
                pc       = src_pc[XLEN*i +: XLEN];
                badv     = src_badv[XLEN*i +: XLEN];
                badv_vld = src_badv_vld[i];
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: exception/interrupt/ERTN sequencer. Arbitrates stage
// exceptions and interrupts, commits ESTAT/ERA/BADV/PRMD/CRMD through a
// single serial CSR write port, flushes the pipeline and redirects fetch.
// ERTN restores CRMD from PRMD and redirects to ERA.
//   src_*, int_*, ertn_req        event inputs (sampled only when idle)
//   *_rdata, ecfg_lie             live CSR values
//   csr_we/waddr/wdata/wmask      serial CSR write port
//   flush, redirect_valid/pc      pipeline control pulses
//   busy, trap_taken, ertn_done   status
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int NSRC = 5,
    parameter int NINT = 13,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NSRC-1:0]      src_ex,
    input  logic [NSRC*6-1:0]    src_ecode,
    input  logic [NSRC*9-1:0]    src_esubcode,
    input  logic [NSRC-1:0]      src_badv_vld,
    input  logic [NSRC*XLEN-1:0] src_badv,
    input  logic [NSRC*XLEN-1:0] src_pc,
    input  logic [NINT-1:0]      int_pending,
    input  logic [XLEN-1:0]      int_pc,
    input  logic                 ertn_req,
    input  logic [XLEN-1:0]      crmd_rdata,
    input  logic [XLEN-1:0]      prmd_rdata,
    input  logic [XLEN-1:0]      era_rdata,
    input  logic [XLEN-1:0]      eentry_rdata,
    input  logic [NINT-1:0]      ecfg_lie,
    output logic                 csr_we,
    output logic [13:0]          csr_waddr,
    output logic [XLEN-1:0]      csr_wdata,
    output logic [XLEN-1:0]      csr_wmask,
    output logic                 flush,
    output logic                 redirect_valid,
    output logic [XLEN-1:0]      redirect_pc,
    output logic                 busy,
    output logic                 trap_taken,
    output logic                 ertn_done
);

    // The CSR port is architecturally 32 bits wide; upper bits stay zero
    // on XLEN=64 builds.
    localparam logic [XLEN-1:0] LO32       = XLEN'({32{1'b1}});
    localparam logic [XLEN-1:0] ESTAT_MASK = XLEN'(32'h7FFF_0000);
    localparam logic [XLEN-1:0] PLVIE_MASK = XLEN'(32'h7);

    state_e state, state_nxt;

    logic            arb_valid;
    ev_kind_e        arb_kind;
    logic [5:0]      arb_ecode;
    logic [8:0]      arb_esub;
    logic [XLEN-1:0] arb_pc, arb_badv;
    logic            arb_badv_vld;

    ev_kind_e        lat_kind;
    logic [5:0]      lat_ecode;
    logic [8:0]      lat_esub;
    logic [XLEN-1:0] lat_pc, lat_badv;
    logic            lat_badv_vld;

    // Only PLV/IE of CRMD/PRMD and the aligned part of EENTRY are consumed.
    logic unused_bits;
    assign unused_bits = &{1'b0, crmd_rdata[XLEN-1:3], prmd_rdata[XLEN-1:3],
                           eentry_rdata[EENTRY_ALIGN-1:0]};

    trap_arbiter #(.NSRC(NSRC), .NINT(NINT), .XLEN(XLEN)) u_arb (
        .src_ex       (src_ex),
        .src_ecode    (src_ecode),
        .src_esubcode (src_esubcode),
        .src_badv_vld (src_badv_vld),
        .src_badv     (src_badv),
        .src_pc       (src_pc),
        .int_pending  (int_pending),
        .ecfg_lie     (ecfg_lie),
        .crmd_ie      (crmd_rdata[2]),
        .int_pc       (int_pc),
        .valid        (arb_valid),
        .kind         (arb_kind),
        .ecode        (arb_ecode),
        .esubcode     (arb_esub),
        .pc           (arb_pc),
        .badv         (arb_badv),
        .badv_vld     (arb_badv_vld)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Event fields are captured only in IDLE; anything arriving while busy
    // is dropped rather than queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_kind     <= EV_EXC;
            lat_ecode    <= '0;
            lat_esub     <= '0;
            lat_pc       <= '0;
            lat_badv     <= '0;
            lat_badv_vld <= 1'b0;
        end else if (state == IDLE) begin
            if (arb_valid) begin
                lat_kind     <= arb_kind;
                lat_ecode    <= arb_ecode;
                lat_esub     <= arb_esub;
                lat_pc       <= arb_pc;
                lat_badv     <= arb_badv;
                lat_badv_vld <= arb_badv_vld;
            end else if (ertn_req) begin
                lat_kind <= EV_ERTN;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (arb_valid)     state_nxt = W_ESTAT;
                else if (ertn_req) state_nxt = E_CRMD;
            end
            W_ESTAT:  state_nxt = W_ERA;
            W_ERA:    state_nxt = lat_badv_vld ? W_BADV : W_PRMD;
            W_BADV:   state_nxt = W_PRMD;
            W_PRMD:   state_nxt = W_CRMD;
            W_CRMD:   state_nxt = REDIRECT;
            E_CRMD:   state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        csr_wmask      = '0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        trap_taken     = 1'b0;
        ertn_done      = 1'b0;
        busy           = (state != IDLE);
        unique case (state)
            W_ESTAT: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_ESTAT;
                csr_wdata = (XLEN'(lat_esub) << ESTAT_ESUB_LSB)
                          | (XLEN'(lat_ecode) << ESTAT_ECODE_LSB);
                csr_wmask = ESTAT_MASK;
            end
            W_ERA: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_ERA;
                csr_wdata = lat_pc & LO32;
                csr_wmask = LO32;
            end
            W_BADV: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_BADV;
                csr_wdata = lat_badv & LO32;
                csr_wmask = LO32;
            end
            W_PRMD: begin
                // Saves the pre-trap PLV/IE; CRMD is cleared only next cycle.
                csr_we    = 1'b1;
                csr_waddr = CSR_PRMD;
                csr_wdata = XLEN'(crmd_rdata[2:0]);
                csr_wmask = PLVIE_MASK;
            end
            W_CRMD: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_CRMD;
                csr_wmask = PLVIE_MASK;
            end
            E_CRMD: begin
                flush     = 1'b1;
                csr_we    = 1'b1;
                csr_waddr = CSR_CRMD;
                csr_wdata = XLEN'(prmd_rdata[2:0]);
                csr_wmask = PLVIE_MASK;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                if (lat_kind == EV_ERTN) begin
                    redirect_pc = era_rdata;
                    ertn_done   = 1'b1;
                end else begin
                    redirect_pc = {eentry_rdata[XLEN-1:EENTRY_ALIGN],
                                   EENTRY_ALIGN'(0)};
                    trap_taken  = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Testbench for trap_sequencer: table-driven vectors, randomized events
// against a reference model, and hand-written busy/reset sequences.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  src_ex;
    logic [29:0] src_ecode;
    logic [44:0] src_esubcode;
    logic [4:0]  src_badv_vld;
    logic [159:0] src_badv, src_pc;
    logic [12:0] int_pending, ecfg_lie;
    logic [31:0] int_pc;
    logic        ertn_req;
    logic [31:0] crmd_rdata, prmd_rdata, era_rdata, eentry_rdata;
    logic        csr_we, flush, redirect_valid, busy, trap_taken, ertn_done;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata, csr_wmask, redirect_pc;

    logic [5:0]  ec  [5];
    logic [8:0]  es  [5];
    logic [31:0] pcs [5];
    logic [31:0] bad [5];

    for (genvar g = 0; g < 5; g++) begin : g_pack
        assign src_ecode[6*g +: 6]    = ec[g];
        assign src_esubcode[9*g +: 9] = es[g];
        assign src_pc[32*g +: 32]     = pcs[g];
        assign src_badv[32*g +: 32]   = bad[g];
    end

    trap_sequencer #(.NSRC(5), .NINT(13), .XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .src_ex(src_ex), .src_ecode(src_ecode), .src_esubcode(src_esubcode),
        .src_badv_vld(src_badv_vld), .src_badv(src_badv), .src_pc(src_pc),
        .int_pending(int_pending), .int_pc(int_pc), .ertn_req(ertn_req),
        .crmd_rdata(crmd_rdata), .prmd_rdata(prmd_rdata),
        .era_rdata(era_rdata), .eentry_rdata(eentry_rdata),
        .ecfg_lie(ecfg_lie),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_wmask(csr_wmask), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy), .trap_taken(trap_taken), .ertn_done(ertn_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
        logic [31:0] m;
    } wr_t;

    // Reference model output
    wr_t         exp_q[$];
    int          exp_kind;   // 0 none, 1 trap, 2 ertn
    int          exp_rc;     // redirect cycle after the sampling edge
    logic [31:0] exp_rpc;

    task automatic push_exp(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        wr_t w;
        w.a = a; w.d = d; w.m = m;
        exp_q.push_back(w);
    endtask

    // Architectural behaviour: pick the oldest excepting stage, else an
    // enabled interrupt, else ERTN; list the CSR writes it must produce.
    task automatic build_expect();
        int win;
        logic ireq;
        logic [5:0] e;
        logic [8:0] s;
        logic [31:0] p, b;
        logic v;
        exp_q.delete();
        exp_kind = 0;
        exp_rpc  = 0;
        win = -1;
        for (int i = 4; i >= 0; i--)
            if (src_ex[i] && win < 0) win = i;
        ireq = crmd_rdata[2] && ((int_pending & ecfg_lie) != 0);
        if (win >= 0 || ireq) begin
            if (win >= 0) begin
                e = ec[win]; s = es[win]; p = pcs[win]; b = bad[win]; v = src_badv_vld[win];
            end else begin
                e = 0; s = 0; p = int_pc; b = 0; v = 0;
            end
            push_exp(14'h5, {1'b0, s, e, 16'h0}, 32'h7FFF_0000);
            push_exp(14'h6, p, 32'hFFFF_FFFF);
            if (v) push_exp(14'h7, b, 32'hFFFF_FFFF);
            push_exp(14'h1, crmd_rdata & 32'h7, 32'h7);
            push_exp(14'h0, 32'h0, 32'h7);
            exp_kind = 1;
            exp_rpc  = eentry_rdata & ~32'h3F;
        end else if (ertn_req) begin
            push_exp(14'h0, prmd_rdata & 32'h7, 32'h7);
            exp_kind = 2;
            exp_rpc  = era_rdata;
        end
        exp_rc = (exp_kind != 0) ? exp_q.size() + 1 : 0;
    endtask

    // Called at a negedge with event inputs already driven. Observes the
    // following 9 cycles and compares against the model.
    task automatic run_event(input string tag, output int n, output logic [31:0] w0,
                             output logic [31:0] w1, output logic [31:0] rpc);
        wr_t got[$];
        wr_t w;
        int fl_n = 0, fl_c = 0, rc = 0, tc = 0, dc = 0, zbad = 0;
        rpc = 0;
        build_expect();
        @(posedge clk);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (csr_we) begin
                w.a = csr_waddr; w.d = csr_wdata; w.m = csr_wmask;
                got.push_back(w);
            end else if (csr_waddr != 0 || csr_wdata != 0 || csr_wmask != 0) zbad++;
            if (flush) begin
                fl_n++;
                if (fl_c == 0) fl_c = c;
            end
            if (redirect_valid) begin
                rc = c;
                rpc = redirect_pc;
            end
            if (trap_taken) tc = c;
            if (ertn_done) dc = c;
            if (c == 1) begin
                src_ex = 0; ertn_req = 0; int_pending = 0;
            end
        end
        n  = got.size();
        w0 = (n > 0) ? got[0].d : 32'h0;
        w1 = (n > 1) ? got[1].d : 32'h0;
        check($sformatf("%s.nwr", tag), n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            check($sformatf("%s.w%0d.addr", tag, i), got[i].a, exp_q[i].a);
            check($sformatf("%s.w%0d.data", tag, i), got[i].d, exp_q[i].d);
            check($sformatf("%s.w%0d.mask", tag, i), got[i].m, exp_q[i].m);
        end
        check($sformatf("%s.flush_n", tag), fl_n, (exp_kind != 0) ? 1 : 0);
        check($sformatf("%s.flush_c", tag), fl_c, (exp_kind != 0) ? 1 : 0);
        check($sformatf("%s.redir_c", tag), rc, exp_rc);
        check($sformatf("%s.redir_pc", tag), rpc, exp_rpc);
        check($sformatf("%s.taken_c", tag), tc, (exp_kind == 1) ? exp_rc : 0);
        check($sformatf("%s.done_c", tag), dc, (exp_kind == 2) ? exp_rc : 0);
        check($sformatf("%s.idle_zero", tag), zbad, 0);
        check($sformatf("%s.busy_end", tag), busy, 0);
    endtask

    task automatic set_defaults();
        src_ex = 0; ertn_req = 0; int_pending = 0; ecfg_lie = 0;
        ec  = '{6'h0A, 6'h0B, 6'h0D, 6'h09, 6'h08};
        es  = '{9'h0, 9'h0, 9'h1FF, 9'h0, 9'h1};
        pcs = '{32'h1C00_0010, 32'h1C00_0110, 32'h1C00_0200, 32'h1C00_0300, 32'h1C00_0100};
        bad = '{32'h55, 32'h55, 32'hDEAD_BEEF, 32'h55, 32'h1003};
        src_badv_vld = 5'b10100;
        int_pc = 32'h2000; crmd_rdata = 0; prmd_rdata = 32'h7;
        era_rdata = 32'h1C00_0204; eentry_rdata = 32'h1C00_8040;
    endtask

    typedef struct {
        logic [4:0]  ex;
        logic        ertn;
        logic [12:0] ip;
        logic [12:0] lie;
        logic [31:0] crmd;
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] rpc;
    } vec_t;

    vec_t tv[9];

    initial begin
        int n, cnt_we, cnt_rd, cnt_done;
        logic [31:0] w0, w1, rpc;

        tv[0] = '{5'b10000, 1'b0, 13'h0,     13'h0,     32'h0, 5, 32'h0048_0000, 32'h1C00_0100, 32'h1C00_8040};
        tv[1] = '{5'b01010, 1'b0, 13'h0,     13'h0,     32'h0, 4, 32'h0009_0000, 32'h1C00_0300, 32'h1C00_8040};
        tv[2] = '{5'b00000, 1'b0, 13'h0800,  13'h0800,  32'h4, 4, 32'h0,         32'h0000_2000, 32'h1C00_8040};
        tv[3] = '{5'b00000, 1'b0, 13'h0800,  13'h0800,  32'h0, 0, 32'h0,         32'h0,         32'h0};
        tv[4] = '{5'b00000, 1'b1, 13'h0,     13'h0,     32'h0, 1, 32'h7,         32'h0,         32'h1C00_0204};
        tv[5] = '{5'b00001, 1'b1, 13'h0,     13'h0,     32'h0, 4, 32'h000A_0000, 32'h1C00_0010, 32'h1C00_8040};
        tv[6] = '{5'b00100, 1'b0, 13'h0,     13'h0,     32'h0, 5, 32'h7FCD_0000, 32'h1C00_0200, 32'h1C00_8040};
        tv[7] = '{5'b00000, 1'b1, 13'h0001,  13'h0001,  32'h7, 4, 32'h0,         32'h0000_2000, 32'h1C00_8040};
        tv[8] = '{5'b00000, 1'b0, 13'h0008,  13'h0800,  32'h4, 0, 32'h0,         32'h0,         32'h0};

        set_defaults();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.outs", {csr_we, flush, redirect_valid, trap_taken, ertn_done}, 0);
        check("reset.port", {csr_waddr, csr_wdata, csr_wmask, redirect_pc}, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            set_defaults();
            src_ex = tv[k].ex; ertn_req = tv[k].ertn; int_pending = tv[k].ip;
            ecfg_lie = tv[k].lie; crmd_rdata = tv[k].crmd;
            run_event($sformatf("vec%0d", k), n, w0, w1, rpc);
            check($sformatf("vec%0d.n", k), n, tv[k].n);
            check($sformatf("vec%0d.w0", k), w0, tv[k].w0);
            check($sformatf("vec%0d.w1", k), w1, tv[k].w1);
            check($sformatf("vec%0d.rpc", k), rpc, tv[k].rpc);
        end

        // Events raised while busy must be dropped, not queued.
        set_defaults();
        src_ex = 5'b10000;
        cnt_we = 0; cnt_rd = 0; cnt_done = 0;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (csr_we) cnt_we++;
            if (redirect_valid) cnt_rd++;
            if (ertn_done) cnt_done++;
            if (c == 1) src_ex = 0;
            if (c == 2) begin
                src_ex = 5'b00001; ertn_req = 1; int_pending = 13'h1; ecfg_lie = 13'h1;
                crmd_rdata = 32'h4;
            end
            if (c == 3) begin
                src_ex = 0; ertn_req = 0; int_pending = 0;
            end
        end
        check("busy.nwr", cnt_we, 5);
        check("busy.nredir", cnt_rd, 1);
        check("busy.ertn", cnt_done, 0);

        // Reset while in W_PRMD aborts without CRMD write or redirect.
        set_defaults();
        src_ex = 5'b10000;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) src_ex = 0;
        end
        check("rst_mid.in_prmd", {csr_we, csr_waddr}, {1'b1, 14'h1});
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.we", csr_we, 0);
        reset = 1'b0;
        cnt_we = 0; cnt_rd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (csr_we) cnt_we++;
            if (redirect_valid) cnt_rd++;
        end
        check("rst_mid.nwr", cnt_we, 0);
        check("rst_mid.nredir", cnt_rd, 0);

        // Randomized events against the model.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 5; i++) begin
                ec[i] = 6'($urandom); es[i] = 9'($urandom);
                pcs[i] = $urandom; bad[i] = $urandom;
            end
            src_badv_vld = 5'($urandom);
            src_ex = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h0;
            ertn_req = 1'($urandom);
            int_pending = 13'($urandom); ecfg_lie = 13'($urandom);
            crmd_rdata = $urandom; prmd_rdata = $urandom;
            era_rdata = $urandom; eentry_rdata = $urandom; int_pc = $urandom;
            run_event($sformatf("rnd%0d", k), n, w0, w1, rpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
